// File: rtl/reset_controller.sv
// Reset sequencer for the f8 system: debounces the board reset button, times the
// system reset hold, and supervises the trap flag with optional auto restart.
//
// state   | meaning
// HOLD    | system_reset high; counts HOLD_CYCLES once the debounced button is up
// RUN     | system running; watches button and trap
// TRAPPED | system halted for inspection; leaves on button or restart delay
module reset_controller #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 16,
  parameter bit AUTORESTART     = 1'b1,
  parameter int RESTART_DELAY   = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_n,
  input  logic       trap,
  output logic       system_reset,
  output logic       trapped,
  output logic [7:0] restart_count,
  output logic [1:0] state
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int DELAY_W = $clog2(RESTART_DELAY + 1);

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DELAY_W-1:0] DELAY_LAST = DELAY_W'(RESTART_DELAY - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RUN     = 2'd1,
    ST_TRAPPED = 2'd2
  } state_t;

  state_t              state_q;
  logic                btn_sync1;
  logic                btn_sync2;
  logic                btn_db;
  logic [DB_W-1:0]     db_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [DELAY_W-1:0]  delay_cnt;

  assign state = state_q;

  // btn_n is asynchronous to clk; two flops before anything looks at it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_sync1 <= 1'b1;
      btn_sync2 <= 1'b1;
      btn_db    <= 1'b1;
      db_cnt    <= '0;
    end else begin
      btn_sync1 <= btn_n;
      btn_sync2 <= btn_sync1;
      if (btn_sync2 != btn_db) begin
        if (db_cnt == DB_LAST) begin
          btn_db <= btn_sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HOLD;
      system_reset  <= 1'b1;
      trapped       <= 1'b0;
      restart_count <= '0;
      hold_cnt      <= '0;
      delay_cnt     <= '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (!btn_db) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state_q      <= ST_RUN;
            system_reset <= 1'b0;
            hold_cnt     <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        // Button wins over trap when both arrive on the same edge.
        ST_RUN: begin
          if (!btn_db) begin
            state_q      <= ST_HOLD;
            system_reset <= 1'b1;
            hold_cnt     <= '0;
          end else if (trap) begin
            state_q   <= ST_TRAPPED;
            trapped   <= 1'b1;
            delay_cnt <= '0;
          end
        end

        ST_TRAPPED: begin
          if (!btn_db) begin
            state_q      <= ST_HOLD;
            system_reset <= 1'b1;
            trapped      <= 1'b0;
            hold_cnt     <= '0;
          end else if (AUTORESTART) begin
            if (delay_cnt == DELAY_LAST) begin
              state_q      <= ST_HOLD;
              system_reset <= 1'b1;
              trapped      <= 1'b0;
              hold_cnt     <= '0;
              if (restart_count != 8'hff) begin
                restart_count <= restart_count + 1'b1;
              end
            end else begin
              delay_cnt <= delay_cnt + 1'b1;
            end
          end else begin
            delay_cnt <= '0;
          end
        end

        default: begin
          state_q      <= ST_HOLD;
          system_reset <= 1'b1;
          trapped      <= 1'b0;
          hold_cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_controller.sv
// Bench for reset_controller: per-edge vector table on an auto-restart instance,
// plus hand sequences for saturation, async reset and the no-autorestart build.
module tb_reset_controller;

  logic       clk = 1'b0;
  logic       reset_n_a, btn_n_a, trap_a;
  logic       sr_a, tr_a;
  logic [7:0] cnt_a;
  logic [1:0] st_a;
  logic       reset_n_b, btn_n_b, trap_b;
  logic       sr_b, tr_b;
  logic [7:0] cnt_b;
  logic [1:0] st_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_controller #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3), .AUTORESTART(1'b1), .RESTART_DELAY(10)
  ) dut_a (
    .clk(clk), .reset_n(reset_n_a), .btn_n(btn_n_a), .trap(trap_a),
    .system_reset(sr_a), .trapped(tr_a), .restart_count(cnt_a), .state(st_a)
  );

  reset_controller #(
    .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(3), .AUTORESTART(1'b0), .RESTART_DELAY(10)
  ) dut_b (
    .clk(clk), .reset_n(reset_n_b), .btn_n(btn_n_b), .trap(trap_b),
    .system_reset(sr_b), .trapped(tr_b), .restart_count(cnt_b), .state(st_b)
  );

  typedef struct {
    logic       btn_n;
    logic       trap;
    int         reps;
    logic       sr;
    logic       tr;
    logic [1:0] st;
    logic [7:0] cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic sr, input logic tr,
                         input logic [1:0] st, input logic [7:0] cnt);
    check({tag, ".system_reset"}, int'(sr_a), int'(sr));
    check({tag, ".trapped"}, int'(tr_a), int'(tr));
    check({tag, ".state"}, int'(st_a), int'(st));
    check({tag, ".restart_count"}, int'(cnt_a), int'(cnt));
  endtask

  initial begin
    // btn_n, trap, reps, system_reset, trapped, state, restart_count
    vecs[0]  = '{1'b1, 1'b0, 2, 1'b1, 1'b0, 2'd0, 8'd0};  // hold after reset
    vecs[1]  = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 2'd1, 8'd0};  // third edge -> RUN
    vecs[2]  = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 2'd1, 8'd0};  // 3-cycle glitch
    vecs[3]  = '{1'b1, 1'b0, 6, 1'b0, 1'b0, 2'd1, 8'd0};  // glitch filtered
    vecs[4]  = '{1'b0, 1'b0, 6, 1'b0, 1'b0, 2'd1, 8'd0};  // press, still RUN
    vecs[5]  = '{1'b0, 1'b0, 2, 1'b1, 1'b0, 2'd0, 8'd0};  // 7th edge -> HOLD
    vecs[6]  = '{1'b1, 1'b0, 8, 1'b1, 1'b0, 2'd0, 8'd0};  // sync+debounce+2 hold
    vecs[7]  = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 2'd1, 8'd0};  // back to RUN
    vecs[8]  = '{1'b1, 1'b1, 1, 1'b0, 1'b1, 2'd2, 8'd0};  // trap -> TRAPPED
    vecs[9]  = '{1'b1, 1'b0, 9, 1'b0, 1'b1, 2'd2, 8'd0};  // delay running
    vecs[10] = '{1'b1, 1'b0, 1, 1'b1, 1'b0, 2'd0, 8'd1};  // 10th edge restart
    vecs[11] = '{1'b1, 1'b0, 2, 1'b1, 1'b0, 2'd0, 8'd1};
    vecs[12] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 2'd1, 8'd1};
    vecs[13] = '{1'b0, 1'b0, 6, 1'b0, 1'b0, 2'd1, 8'd1};  // press in flight
    vecs[14] = '{1'b0, 1'b1, 1, 1'b1, 1'b0, 2'd0, 8'd1};  // trap + press: HOLD
    vecs[15] = '{1'b1, 1'b0, 8, 1'b1, 1'b0, 2'd0, 8'd1};
    vecs[16] = '{1'b1, 1'b0, 1, 1'b0, 1'b0, 2'd1, 8'd1};

    reset_n_a = 1'b0; btn_n_a = 1'b1; trap_a = 1'b0;
    reset_n_b = 1'b0; btn_n_b = 1'b1; trap_b = 1'b0;
    #7;
    check_a("reset", 1'b1, 1'b0, 2'd0, 8'd0);
    reset_n_a = 1'b1;

    for (int v = 0; v < NVEC; v++) begin
      btn_n_a = vecs[v].btn_n;
      trap_a  = vecs[v].trap;
      for (int r = 0; r < vecs[v].reps; r++) begin
        step();
        check_a($sformatf("vec%0d.%0d", v, r), vecs[v].sr, vecs[v].tr,
                vecs[v].st, vecs[v].cnt);
      end
    end

    // Saturation: trap held high gives one restart every 14 edges from RUN.
    trap_a = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      for (int e = 0; e < 14; e++) step();
      if (k == 100) check_a("sat100", 1'b0, 1'b0, 2'd1, 8'd101);
      if (k == 254) check_a("sat254", 1'b0, 1'b0, 2'd1, 8'd255);
      if (k == 300) check_a("sat300", 1'b0, 1'b0, 2'd1, 8'd255);
    end

    // Async reset while TRAPPED.
    for (int e = 0; e < 5; e++) step();
    check_a("pre_rst_trapped", 1'b0, 1'b1, 2'd2, 8'd255);
    reset_n_a = 1'b0;
    #1;
    check_a("async_rst", 1'b1, 1'b0, 2'd0, 8'd0);
    trap_a = 1'b0;

    // No-autorestart instance.
    reset_n_b = 1'b1;
    step(); step(); step();
    check("b_run.state", int'(st_b), 1);
    check("b_run.system_reset", int'(sr_b), 0);
    trap_b = 1'b1;
    step();
    trap_b = 1'b0;
    check("b_trap.state", int'(st_b), 2);
    check("b_trap.trapped", int'(tr_b), 1);
    begin
      int bad;
      bad = 0;
      for (int e = 0; e < 1000; e++) begin
        step();
        if (st_b != 2'd2 || tr_b != 1'b1 || sr_b != 1'b0 || cnt_b != 8'd0) bad++;
      end
      check("b_trapped_1000_bad_cycles", bad, 0);
    end
    btn_n_b = 1'b0;
    for (int e = 0; e < 6; e++) step();
    check("b_press6.state", int'(st_b), 2);
    step();
    check("b_press7.state", int'(st_b), 0);
    check("b_press7.system_reset", int'(sr_b), 1);
    check("b_press7.trapped", int'(tr_b), 0);
    check("b_press7.restart_count", int'(cnt_b), 0);
    btn_n_b = 1'b1;
    for (int e = 0; e < 8; e++) step();
    check("b_rel8.state", int'(st_b), 0);
    step();
    check("b_rel9.state", int'(st_b), 1);
    check("b_rel9.restart_count", int'(cnt_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
